// File: rtl/alu_exec_unit.sv
// alu_exec_unit: PC+4 incrementer, branch-target adder, and main ALU with an EX/MEM result register.
// Define ALU_OVERFLOW_EN to enable signed-overflow detection on ADD/SUB.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [31:0] br_base,
  input  logic [31:0] br_imm,
  output logic [31:0] br_target,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  alu_op,
  input  logic        alu_en,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] alu_out_q,
  output logic        zero_q,
  output logic        overflow_q
);
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] r_out;
  logic        r_zero;
  assign pc_plus4  = pc + 32'd4;
  assign br_target = br_base + (br_imm << 2);
  assign w_sum     = src_a + src_b;
  assign w_diff    = src_a - src_b;
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      4'b0000: alu_out = src_a & src_b;
      4'b0001: alu_out = src_a | src_b;
      4'b0010: alu_out = w_sum;
      4'b0011: alu_out = src_a ^ src_b;
      4'b0100: alu_out = src_b << shamt;
      4'b0101: alu_out = src_b >> shamt;
      4'b0110: alu_out = w_diff;
      4'b0111: alu_out = {31'd0, $signed(src_a) < $signed(src_b)};
      4'b1000: alu_out = $signed(src_b) >>> shamt;
      4'b1001: alu_out = {31'd0, src_a < src_b};
      4'b1010: alu_out = {src_b[15:0], 16'd0};
      4'b1100: alu_out = ~(src_a | src_b);
      default: alu_out = 32'd0;
    endcase
  end
  assign zero = (alu_out == 32'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= 32'd0;
      r_zero <= 1'b1;
    end else if (alu_en) begin
      r_out  <= alu_out;
      r_zero <= zero;
    end
  end
  assign alu_out_q = r_out;
  assign zero_q    = r_zero;
`ifdef ALU_OVERFLOW_EN
  logic r_ov;
  // Overflow when operand signs (b inverted for SUB) agree but the result sign differs.
  assign overflow = (alu_op == 4'b0010) ? (src_a[31] == src_b[31]) && (w_sum[31] != src_a[31]) :
                    (alu_op == 4'b0110) ? (src_a[31] != src_b[31]) && (w_diff[31] != src_a[31]) : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ov <= 1'b0;
    else if (alu_en) r_ov <= overflow;
  end
  assign overflow_q = r_ov;
`else
  assign overflow   = 1'b0;
  assign overflow_q = 1'b0;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_alu_exec_unit;
`ifdef ALU_OVERFLOW_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic [31:0] pc = 0, br_base = 0, br_imm = 0, src_a = 0, src_b = 0;
  logic [4:0]  shamt = 0;
  logic [3:0]  alu_op = 0;
  logic        alu_en = 0;
  logic [31:0] pc_plus4, br_target, alu_out, alu_out_q;
  logic        zero, overflow, zero_q, overflow_q;
  int total = 0, bad = 0;
  typedef struct {
    string       n;
    logic [31:0] pp4, bt, out;
    logic        z, ov;
    logic [31:0] q;
    logic        zq, ovq;
  } exp_t;
  exp_t sb[$];
  alu_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4),
    .br_base(br_base), .br_imm(br_imm), .br_target(br_target),
    .src_a(src_a), .src_b(src_b), .shamt(shamt), .alu_op(alu_op), .alu_en(alu_en),
    .alu_out(alu_out), .zero(zero), .overflow(overflow),
    .alu_out_q(alu_out_q), .zero_q(zero_q), .overflow_q(overflow_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.n, "pc_plus4", pc_plus4, e.pp4);
      chk(e.n, "br_target", br_target, e.bt);
      chk(e.n, "alu_out", alu_out, e.out);
      chk(e.n, "zero", {31'd0, zero}, {31'd0, e.z});
      chk(e.n, "overflow", {31'd0, overflow}, {31'd0, e.ov});
      chk(e.n, "alu_out_q", alu_out_q, e.q);
      chk(e.n, "zero_q", {31'd0, zero_q}, {31'd0, e.zq});
      chk(e.n, "overflow_q", {31'd0, overflow_q}, {31'd0, e.ovq});
    end
  end
  // Inputs change 1 time unit after the rising edge; the monitor samples at the following falling edge.
  task automatic vec(input string n, input logic rst, input logic [31:0] p, bb, bi, a, b,
                     input logic [4:0] sh, input logic [3:0] op, input logic en,
                     input logic [31:0] e_pp4, e_bt, e_out, input logic e_z, e_ov,
                     input logic [31:0] e_q, input logic e_zq, e_ovq);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; pc = p; br_base = bb; br_imm = bi; src_a = a; src_b = b;
    shamt = sh; alu_op = op; alu_en = en;
    e = '{n, e_pp4, e_bt, e_out, e_z, e_ov, e_q, e_zq, e_ovq};
    sb.push_back(e);
  endtask
  localparam logic [31:0] P0 = 32'h00400000, BB = 32'h00400008, BI = 32'hFFFFFFFE;
  localparam logic [31:0] PP = 32'h00400004, BT = 32'h00400000;
  initial begin
    vec("reset", 0, P0, BB, BI, 0, 0, 0, 4'b0000, 0, PP, BT, 0, 1, 0, 0, 1, 0);
    vec("sub_eq", 1, 32'hFFFFFFFC, BB, 32'h3, 32'h12345678, 32'h12345678, 0, 4'b0110, 1,
        0, 32'h00400014, 0, 1, 0, 0, 1, 0);
    vec("add_ov", 1, P0, BB, BI, 32'h7FFFFFFF, 1, 0, 4'b0010, 1, PP, BT, 32'h80000000, 0, OV, 0, 1, 0);
    vec("slt", 1, P0, BB, BI, 32'h80000000, 1, 0, 4'b0111, 0, PP, BT, 1, 0, 0, 32'h80000000, 0, OV);
    vec("sltu", 1, P0, BB, BI, 32'h80000000, 1, 0, 4'b1001, 0, PP, BT, 0, 1, 0, 32'h80000000, 0, OV);
    vec("sra", 1, P0, BB, BI, 0, 32'h80000000, 4, 4'b1000, 0, PP, BT, 32'hF8000000, 0, 0, 32'h80000000, 0, OV);
    vec("and", 1, P0, BB, BI, 32'hF0F0F0F0, 32'hFF00FF00, 0, 4'b0000, 0, PP, BT, 32'hF000F000, 0, 0, 32'h80000000, 0, OV);
    vec("or", 1, P0, BB, BI, 32'hF0F0F0F0, 32'hFF00FF00, 0, 4'b0001, 0, PP, BT, 32'hFFF0FFF0, 0, 0, 32'h80000000, 0, OV);
    vec("xor", 1, P0, BB, BI, 32'hF0F0F0F0, 32'hFF00FF00, 0, 4'b0011, 0, PP, BT, 32'h0FF00FF0, 0, 0, 32'h80000000, 0, OV);
    vec("nor", 1, P0, BB, BI, 32'hF0F0F0F0, 32'hFF00FF00, 0, 4'b1100, 0, PP, BT, 32'h000F000F, 0, 0, 32'h80000000, 0, OV);
    vec("sll", 1, P0, BB, BI, 0, 1, 31, 4'b0100, 0, PP, BT, 32'h80000000, 0, 0, 32'h80000000, 0, OV);
    vec("srl", 1, P0, BB, BI, 0, 32'h80000000, 4, 4'b0101, 0, PP, BT, 32'h08000000, 0, 0, 32'h80000000, 0, OV);
    vec("lui", 1, P0, BB, BI, 0, 32'h1234ABCD, 0, 4'b1010, 0, PP, BT, 32'hABCD0000, 0, 0, 32'h80000000, 0, OV);
    vec("undef", 1, P0, BB, BI, 5, 5, 0, 4'b1011, 0, PP, BT, 0, 1, 0, 32'h80000000, 0, OV);
    vec("sub_ov", 1, P0, BB, BI, 32'h80000000, 1, 0, 4'b0110, 0, PP, BT, 32'h7FFFFFFF, 0, OV, 32'h80000000, 0, OV);
    vec("slt_ovf", 1, P0, BB, BI, 32'h7FFFFFFF, 32'h80000000, 0, 4'b0111, 0, PP, BT, 0, 1, 0, 32'h80000000, 0, OV);
    vec("add_plain", 1, P0, BB, BI, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 4'b0010, 0, PP, BT, 32'h7FFFFFFE, 0, 0, 32'h80000000, 0, OV);
    vec("load", 1, P0, BB, BI, 32'hDEADBEEF, 0, 0, 4'b0001, 1, PP, BT, 32'hDEADBEEF, 0, 0, 32'h80000000, 0, OV);
    vec("loaded", 1, P0, BB, BI, 32'hDEADBEEF, 0, 0, 4'b0001, 0, PP, BT, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0);
    vec("async_rst", 0, P0, BB, BI, 32'hDEADBEEF, 0, 0, 4'b0001, 1, PP, BT, 32'hDEADBEEF, 0, 0, 0, 1, 0);
    vec("hold1", 1, P0, BB, BI, 1, 1, 0, 4'b0010, 0, PP, BT, 2, 0, 0, 0, 1, 0);
    vec("hold2", 1, P0, BB, BI, 1, 1, 0, 4'b0010, 0, PP, BT, 2, 0, 0, 0, 1, 0);
    vec("capture", 1, P0, BB, BI, 3, 4, 0, 4'b0010, 1, PP, BT, 7, 0, 0, 0, 1, 0);
    vec("captured", 1, P0, BB, BI, 3, 4, 0, 4'b0010, 0, PP, BT, 7, 0, 0, 7, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Combinational datapath arithmetic for the pipelined MIPS core, plus one registered result stage. It provides the PC+4 incrementer for the IF stage, the branch-target adder for the ID stage, and the main ALU for the EX stage. The ALU result and flags are also captured into an output register feeding the EX/MEM boundary.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  32  current fetch PC.
- pc_plus4  out  32  pc + 4, combinational.
- br_base  in  32  PC+4 of the branch instruction.
- br_imm  in  32  sign-extended 16-bit immediate.
- br_target  out  32  br_base + (br_imm << 2), combinational.
- src_a  in  32  ALU operand A (rs value).
- src_b  in  32  ALU operand B (rt value or immediate).
- shamt  in  5  shift amount for shift ops.
- alu_op  in  4  operation select.
- alu_en  in  1  load enable for the result register.
- alu_out  out  32  ALU result, combinational.
- zero  out  1  high when alu_out == 0, combinational.
- overflow  out  1  signed overflow on ADD/SUB, combinational.
- alu_out_q  out  32  registered alu_out.
- zero_q  out  1  registered zero.
- overflow_q  out  1  registered overflow.

## Operation
- alu_op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL b by shamt, 0101 SRL b by shamt, 1000 SRA b by shamt.
  - 0110 SUB (a − b), 0111 SLT signed (result 1/0), 1001 SLTU unsigned.
  - 1010 LUI (b[15:0] << 16), 1100 NOR.
  - All other codes: result 0.
- All add/sub results wrap modulo 2^32; no exceptions are raised.
- SLT compares correctly even when a − b overflows, i.e. it uses the true signed compare, not the sign of the difference.
- pc_plus4 and br_target wrap modulo 2^32. The shift in br_target discards imm[31:30].
- zero reflects alu_out for every op, including undefined codes (result 0, so zero = 1).
- overflow is asserted only for ADD/SUB on signed overflow; it is 0 for all other ops.

## Timing
- pc_plus4, br_target, alu_out, zero and overflow are purely combinational, with zero latency.
- Registered outputs update on the rising clk edge when alu_en = 1 and hold their value when alu_en = 0. Latency is 1 cycle.
- rst_n low: alu_out_q = 0, zero_q = 1, overflow_q = 0, immediately and asynchronously, regardless of clk or alu_en.
- Reset deassertion takes effect at the next rising edge. A capture on the same edge that rst_n rises is not guaranteed.
- Combinational outputs are unaffected by rst_n.

## Configuration
- ALU_OVERFLOW_EN defined: overflow is computed as specified and overflow_q is captured.
- ALU_OVERFLOW_EN undefined: overflow and overflow_q are tied to 0, and the detection logic is omitted.
- All other behaviour is identical in both builds.

## Test plan
- pc = 0x00400000 → pc_plus4 = 0x00400004. pc = 0xFFFFFFFC → pc_plus4 = 0x00000000.
- br_base = 0x00400008:
  - br_imm = 0xFFFFFFFE → br_target = 0x00400000.
  - br_imm = 0x00000003 → br_target = 0x00400014.
- SUB with a = b = 0x12345678 → alu_out = 0, zero = 1. Then alu_en = 1 and one clk edge → alu_out_q = 0, zero_q = 1.
- ADD 0x7FFFFFFF + 1 → alu_out = 0x80000000, overflow = 1 (0 without ALU_OVERFLOW_EN).
- SLT 0x80000000 vs 1 → 1. SLTU for the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- Load alu_out_q = 0xDEADBEEF, then pull rst_n low mid-cycle with no clk edge → alu_out_q = 0 and zero_q = 1 immediately. With alu_en = 0 after release, the register holds across edges.
